// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared stopwatch state encodings, digit constants and BCD step helper
package lab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    localparam logic [3:0]  DIGIT_MIN = 4'd0;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;
    localparam logic [15:0] BCD_ZERO  = {4{DIGIT_MIN}};
    localparam logic [15:0] BCD_NINES = {4{DIGIT_MAX}};

    localparam int TICK_DIV_DEFAULT  = 10_000_000;
    localparam int DB_CYCLES_DEFAULT = 65_536;

    // One count step on four BCD digits; the carry/borrow ripples from BCD0 upward.
    function automatic logic [15:0] bcd_step(input logic [15:0] value, input logic down);
        logic [15:0] result;
        logic        carry;
        logic [3:0]  digit;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            digit = value[i*4 +: 4];
            if (carry) begin
                if (!down) begin
                    if (digit == DIGIT_MAX) begin
                        digit = DIGIT_MIN;
                        carry = 1'b1;
                    end else begin
                        digit = digit + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == DIGIT_MIN) begin
                        digit = DIGIT_MAX;
                        carry = 1'b1;
                    end else begin
                        digit = digit - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            result[i*4 +: 4] = digit;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce_onepulse.sv
// rtl/btn_debounce_onepulse.sv - button synchroniser, debouncer and rising-edge one-pulse
module btn_debounce_onepulse
    import lab_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the accepted level.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - four-digit BCD up/down stopwatch with start/pause and clear buttons
module bcd_stopwatch
    import lab_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        dir,
    output logic [15:0] bcd,
    output logic        running,
    output logic        done
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic             start_p, clear_p;
    logic             dir_s1_q, dir_s1_d;
    logic             dir_s2_q, dir_s2_d;
    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic [15:0]      step;
    logic [15:0]      limit;
    logic             tick;

    btn_debounce_onepulse #(.DB_CYCLES(DB_CYCLES)) u_db_start (
        .clk     (clk),
        .rst_n   (reset),
        .btn_raw (btn_start),
        .pulse   (start_p)
    );

    btn_debounce_onepulse #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk     (clk),
        .rst_n   (reset),
        .btn_raw (btn_clear),
        .pulse   (clear_p)
    );

    always_comb begin
        dir_s1_d   = dir;
        dir_s2_d   = dir_s1_q;
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bcd_d      = bcd_q;
        step       = bcd_step(bcd_q, dir_s2_q);
        limit      = dir_s2_q ? BCD_ZERO : BCD_NINES;
        tick       = (tick_cnt_q == TICK_LAST);

        if (clear_p) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
            bcd_d      = dir_s2_q ? BCD_NINES : BCD_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_p) begin
                        state_d    = ST_RUN;
                        tick_cnt_d = '0;
                    end
                end
                ST_RUN: begin
                    if (start_p) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        tick_cnt_d = '0;
                        // Sitting on the limit already: stop without wrapping the display.
                        if (bcd_q == limit) begin
                            state_d = ST_DONE;
                        end else begin
                            bcd_d = step;
                            if (step == limit) begin
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (start_p) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_s1_q   <= 1'b0;
            dir_s2_q   <= 1'b0;
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bcd_q      <= BCD_ZERO;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            dir_s1_q   <= dir_s1_d;
            dir_s2_q   <= dir_s2_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bcd_q      <= bcd_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

    assign bcd     = bcd_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb/tb_bcd_stopwatch.sv - scoreboard bench for bcd_stopwatch against an integer-valued reference model
module tb_bcd_stopwatch;

    localparam int TICK_DIV = 4;
    localparam int DB       = 3;
    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSE  = 2;
    localparam int S_DONE   = 3;

    logic        clk;
    logic        reset;
    logic        btn_start;
    logic        btn_clear;
    logic        dir;
    logic [15:0] bcd;
    logic        running;
    logic        done;

    int errors = 0;
    int checks = 0;
    bit tb_done = 1'b0;

    logic [17:0] exp_q[$];

    bit sy1[3];
    bit sy2[3];
    bit run_val[2];
    int run_len[2];
    bit acc[2];
    bit pls[2];
    int m_state;
    int m_phase;
    int m_val;

    bcd_stopwatch #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .dir       (dir),
        .bcd       (bcd),
        .running   (running),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            sy1[b] = 1'b0;
            sy2[b] = 1'b0;
        end
        for (int b = 0; b < 2; b++) begin
            run_val[b] = 1'b0;
            run_len[b] = 0;
            acc[b]     = 1'b0;
            pls[b]     = 1'b0;
        end
        m_state = S_IDLE;
        m_phase = 0;
        m_val   = 0;
        exp_q.delete();
        exp_q.push_back(18'd0);
    endtask

    // One clock edge of the reference: pulses and dir seen here are those produced by the previous edge.
    task automatic model_step();
        bit dn;
        bit sp;
        bit cp;
        bit raw[3];
        int lim;
        dn     = sy2[2];
        sp     = pls[0];
        cp     = pls[1];
        raw[0] = btn_start;
        raw[1] = btn_clear;
        raw[2] = dir;
        lim    = dn ? 0 : 9999;

        if (cp) begin
            m_state = S_IDLE;
            m_phase = 0;
            m_val   = dn ? 9999 : 0;
        end else if (m_state == S_IDLE) begin
            if (sp) begin
                m_state = S_RUN;
                m_phase = 0;
            end
        end else if (m_state == S_RUN) begin
            if (sp) begin
                m_state = S_PAUSE;
            end else if (m_phase == TICK_DIV - 1) begin
                m_phase = 0;
                if (m_val == lim) begin
                    m_state = S_DONE;
                end else begin
                    m_val = dn ? m_val - 1 : m_val + 1;
                    if (m_val == lim) m_state = S_DONE;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end else if (m_state == S_PAUSE) begin
            if (sp) m_state = S_RUN;
        end

        for (int b = 0; b < 2; b++) begin
            if (sy2[b] == run_val[b]) begin
                run_len[b] = run_len[b] + 1;
            end else begin
                run_val[b] = sy2[b];
                run_len[b] = 1;
            end
            pls[b] = 1'b0;
            if (run_len[b] >= DB && run_val[b] != acc[b]) begin
                acc[b] = run_val[b];
                pls[b] = run_val[b];
            end
        end

        for (int b = 0; b < 3; b++) begin
            sy2[b] = sy1[b];
            sy1[b] = raw[b];
        end

        exp_q.push_back({to_bcd(m_val), m_state == S_RUN, m_state == S_DONE});
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // Reset falling is checked one step later, with no clock edge in between.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk or negedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({bcd, running, done} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got bcd=%h running=%b done=%b expected bcd=%h running=%b done=%b",
                             $time, bcd, running, done, e[17:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        if (!tb_done) begin
            errors++;
            $display("FAIL timeout t=%0t stimulus did not complete", $time);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        if (which == 0 || which == 2) btn_start = v;
        if (which == 1 || which == 2) btn_clear = v;
    endtask

    task automatic press(input int which, input int bounce);
        for (int i = 0; i < bounce; i++) begin
            set_btn(which, 1'b1);
            wait_cycles(1);
            set_btn(which, 1'b0);
            wait_cycles(1);
        end
        set_btn(which, 1'b1);
        wait_cycles(DB + 6);
        for (int i = 0; i < bounce; i++) begin
            set_btn(which, 1'b0);
            wait_cycles(1);
            set_btn(which, 1'b1);
            wait_cycles(1);
        end
        set_btn(which, 1'b0);
        wait_cycles(DB + 6);
    endtask

    initial begin
        reset     = 1'b1;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        dir       = 1'b0;
        #2 reset  = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(10);

        // count up, then asynchronous reset in the middle of a count
        press(0, 2);
        wait_cycles(480);
        reset = 1'b0;
        #1;
        checks++;
        if (bcd !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset state t=%0t got bcd=%h running=%b done=%b expected bcd=0000 running=0 done=0",
                     $time, bcd, running, done);
        end
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(20);

        // long up-count through 0999->1000, pause/resume, then reverse through 1000->0999
        press(0, 2);
        wait_cycles(4200);
        press(0, 1);
        wait_cycles(20);
        press(0, 0);
        wait_cycles(30);
        dir = 1'b1;
        wait_cycles(260);

        // clear to 9999, count down a little, reverse to reach 9999 and DONE, start ignored
        press(1, 2);
        press(0, 2);
        wait_cycles(10);
        dir = 1'b0;
        wait_cycles(40);
        press(0, 2);
        wait_cycles(20);

        // clear to 0000, count up, reverse down to 0000 and DONE
        press(1, 1);
        press(0, 1);
        wait_cycles(20);
        dir = 1'b1;
        wait_cycles(120);

        // start and clear together while running
        dir = 1'b0;
        press(1, 0);
        press(0, 0);
        wait_cycles(30);
        press(2, 0);
        wait_cycles(20);

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 5))
                0, 1: press(0, $urandom_range(0, 3));
                2: press(1, $urandom_range(0, 3));
                3: dir = ~dir;
                4: wait_cycles($urandom_range(1, 60));
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        reset = 1'b0;
                        wait_cycles(1);
                        reset = 1'b1;
                    end else begin
                        wait_cycles(5);
                    end
                end
            endcase
        end
        wait_cycles(10);

        tb_done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
